uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
// - Shares one 8N1 UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
// - Generates the transmitter baud strobe (tx_enb) and the byte load strobe (wr_enb).
// - Sequences each byte: grant, load, wait for the transmitter to go busy, wait for it to go idle.
// - Sits between client logic and the transmitter; tx_busy is driven by the transmitter's busy output.
// PARAMETERS
// - NUM_REQ      4           number of requesters (2..8)
// - CLK_FREQ     50_000_000  i_clk frequency, Hz
// - BAUD         115200      line rate, bit/s
// - CLKS_PER_BIT CLK_FREQ/BAUD  clocks per baud tick (localparam, >=2)
// PORTS
// - i_clk      in   1            clock, all logic on posedge
// - i_rst      in   1            synchronous reset, active-high
// - req        in   NUM_REQ      per-requester byte-pending; held until ack
// - req_data   in   8*NUM_REQ    packed bytes; requester k uses [8k+7:8k]
// - ack        out  NUM_REQ      one-cycle pulse: byte of requester k captured
// - tx_busy    in   1            transmitter busy (high when transmitter not idle)
// - wr_enb     out  1            one-cycle load strobe to transmitter
// - tx_data    out  8            byte to transmitter, valid while wr_enb=1
// - tx_enb     out  1            baud tick, one cycle every CLKS_PER_BIT clocks
// - grant_id   out  clog2(NUM_REQ)  index of last granted requester
// - ctrl_busy  out  1            high whenever FSM is not IDLE
// BEHAVIOUR
// - Reset values: ack=0, wr_enb=0, tx_data=0, tx_enb=0, grant_id=0, ctrl_busy=0, FSM=IDLE.
// - Reset sets the RR pointer to NUM_REQ-1, so requester 0 has first priority.
// - Baud counter: free-running 0..CLKS_PER_BIT-1, reset to 0.
//   - tx_enb=1 in the cycle the count equals CLKS_PER_BIT-1.
//   - The counter is independent of FSM state.
// - FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
//   - IDLE: if |req && !tx_busy:
//     - pick the first k with req[k]=1, searching from (ptr+1) mod NUM_REQ upward with wrap.
//     - register tx_data=req_data[k], grant_id=k, ptr=k; go to LOAD.
//     - tx_busy=1 in IDLE (e.g. after a reset mid-frame) blocks any grant.
//   - LOAD: wr_enb=1 and ack[k]=1 for exactly this cycle; go to WAIT_START.
//   - WAIT_START: on tx_busy=1 go to WAIT_DONE. No timeout.
//   - WAIT_DONE: on tx_busy=0 go to IDLE. The next grant comes no earlier than the following cycle.
// - Latency: req rise in IDLE -> wr_enb 1 cycle later -> ack in the same cycle as wr_enb.
// - The requester may change req_data or drop req from the cycle after ack.
//   - If req is still high after ack, the next byte is pending.
// - req changes outside IDLE are ignored until the next IDLE cycle (no preemption).
// - At most one ack bit is set in any cycle; ack and wr_enb are always coincident.
// - i_rst mid-operation: FSM returns to IDLE and all outputs return to reset values next cycle.
//   - The in-flight transmitter byte is not aborted.
// CONFIGURATION
// - Macro UART_TX_SCHED_LOCK_EN.
// - Defined: adds input port lock (NUM_REQ bits).
//   - In IDLE, if req[grant_id] && lock[grant_id], grant_id is re-granted, bypassing round-robin.
//   - This is a multi-byte burst lock; the pointer is unchanged.
// - Undefined: no lock port; pure round-robin.
// TESTING
// - Reset: i_rst=1 for 2 cycles with req=4'hF -> ack=0, wr_enb=0, tx_enb=0, grant_id=0, ctrl_busy=0.
// - Baud: CLKS_PER_BIT=4, i_rst released at cycle 0 -> tx_enb=1 at cycles 3, 7, 11, 15 only.
// - Single byte: req=4'b0001, data0=8'hA5, transmitter attached:
//   - wr_enb and ack=4'b0001 one cycle; tx_data=A5.
//   - Line shows 0, then 1,0,1,0,0,1,0,1, then 1; ctrl_busy falls after tx_busy falls.
// - Round-robin: req=4'hF held, unique data per requester -> grant order 0,1,2,3,0,1; one ack per frame.
// - Reset mid-frame: i_rst in WAIT_DONE with tx_busy held 1 -> FSM in IDLE, no wr_enb until tx_busy=0.
//   - Then requester 0 is granted first.
// - Lock (macro on): req=4'b0110, lock=4'b0100 after first grant to 2 -> grants 2,2,2.
//   - Then clear lock -> grant 1.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the UART TX scheduler and its clients/transmitter.
// The scheduler uses the master modport; the requesters and transmitter use the slave modport.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]         req;
    logic [8*NUM_REQ-1:0]       req_data;
    logic [NUM_REQ-1:0]         ack;
    logic                       tx_busy;
    logic                       wr_enb;
    logic [7:0]                 tx_data;
    logic                       tx_enb;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       ctrl_busy;

    modport master (
        input  req, req_data, tx_busy,
        output ack, wr_enb, tx_data, tx_enb, grant_id, ctrl_busy
    );

    modport slave (
        output req, req_data, tx_busy,
        input  ack, wr_enb, tx_data, tx_enb, grant_id, ctrl_busy
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between NUM_REQ requesters.
// Optional burst lock (extra `lock` port) is enabled by defining UART_TX_SCHED_LOCK_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic               i_clk,
    input  logic               i_rst,
`ifdef UART_TX_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    uart_tx_scheduler_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int IDW          = $clog2(NUM_REQ);
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_PRE = CW'(CLKS_PER_BIT - 2);
    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [IDW-1:0]     ptr_r, ptr_s;
    logic [IDW-1:0]     grant_r, grant_s;
    logic [IDW-1:0]     pick_s;
    logic [7:0]         data_r, data_s;
    logic [NUM_REQ-1:0] ack_r, ack_s;
    logic               wr_r, wr_s;
    logic               busy_r;
    logic [CW-1:0]      cnt_r;
    logic               tx_enb_r;

    // First requester at or after p+1 (with wrap); lowest offset wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     p);
        logic [IDW-1:0] sel;
        logic [IDW-1:0] idx;
        int             j;
        sel = p;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(p) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = IDW'(j);
            if (r[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    // Free-running baud counter; tx_enb is registered one count early so it lands on CNT_MAX.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r    <= '0;
            tx_enb_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            tx_enb_r <= (cnt_r == CNT_PRE);
        end
    end

    // Next-state and next-output logic; strobes are computed on entry to LOAD.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        grant_s = grant_r;
        data_s  = data_r;
        ack_s   = '0;
        wr_s    = 1'b0;
        pick_s  = rr_pick(bus.req, ptr_r);
        case (state_r)
            ST_IDLE: begin
                if ((|bus.req) && !bus.tx_busy) begin
`ifdef UART_TX_SCHED_LOCK_EN
                    if (bus.req[grant_r] && lock[grant_r]) begin
                        grant_s = grant_r;
                    end else begin
                        grant_s = pick_s;
                        ptr_s   = pick_s;
                    end
`else
                    grant_s = pick_s;
                    ptr_s   = pick_s;
`endif
                    data_s  = bus.req_data[{grant_s, 3'b000} +: 8];
                    ack_s   = NUM_REQ'(1) << grant_s;
                    wr_s    = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (bus.tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    state_s = ST_WAIT_START;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, arbitration pointer and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_RST;
            grant_r <= '0;
            data_r  <= 8'h00;
            ack_r   <= '0;
            wr_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
            data_r  <= data_s;
            ack_r   <= ack_s;
            wr_r    <= wr_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign bus.ack       = ack_r;
    assign bus.wr_enb    = wr_r;
    assign bus.tx_data   = data_r;
    assign bus.tx_enb    = tx_enb_r;
    assign bus.grant_id  = grant_r;
    assign bus.ctrl_busy = busy_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural 8N1 transmitter (CLKS_PER_BIT = 4).
module tb_uart_tx_scheduler;
    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       tb_busy = 1'b0;
    logic       force_busy = 1'b0;
    logic [9:0] sreg = 10'h3FF;
    logic [9:0] frame = 10'h000;
    int         nbits = 0;
    int         frames = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    logic       wr_seen;

    uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

`ifdef UART_TX_SCHED_LOCK_EN
    logic [NR-1:0] lock = '0;
`endif

    uart_tx_scheduler #(
        .NUM_REQ (NR),
        .CLK_FREQ(400),
        .BAUD    (100)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
`ifdef UART_TX_SCHED_LOCK_EN
        .lock (lock),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_busy = tb_busy | force_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: shifts start/data/stop out on baud ticks; ignores i_rst.
    always @(posedge clk) begin
        if (!tb_busy) begin
            if (bus.wr_enb === 1'b1) begin
                sreg    <= {1'b1, bus.tx_data, 1'b0};
                nbits   <= 0;
                tb_busy <= 1'b1;
            end
        end else if (bus.tx_enb === 1'b1) begin
            frame[nbits] <= sreg[0];
            sreg         <= {1'b1, sreg[9:1]};
            nbits        <= nbits + 1;
            if (nbits == 9) tb_busy <= 1'b0;
        end
    end

    // Scoreboard monitor: every load strobe pops one expected {grant, data}.
    always @(negedge clk) begin
        logic [9:0] e;
        if (bus.wr_enb === 1'b1 || (|bus.ack) === 1'b1) begin
            check("ack_wr_coincide", {31'd0, |bus.ack}, {31'd0, bus.wr_enb});
        end
        if (bus.wr_enb === 1'b1) begin
            frames++;
            wr_seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant_id", 32'(bus.grant_id), 32'(e[9:8]));
                check("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
                check("ack_onehot", 32'(bus.ack), 32'(4'b0001 << e[9:8]));
            end
        end
    end

    task automatic push(input int id, input logic [7:0] d);
        logic [1:0] i2;
        i2 = 2'(id);
        exp_q.push_back({i2, d});
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n;
        n = 0;
        while (frames < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (frames < target) check(tag, 32'(frames), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((bus.ctrl_busy !== 1'b0 || bus.tx_busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check(tag, 32'(bus.ctrl_busy), 32'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        i_rst        = 1'b1;
        bus.req      = 4'hF;
        bus.req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        wr_seen      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_wr_enb", 32'(bus.wr_enb), 32'd0);
        check("rst_tx_enb", 32'(bus.tx_enb), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        bus.req = 4'h0;
        i_rst   = 1'b0;

        // Baud strobe: cycle 0 is the first cycle after the last reset edge.
        for (int c = 0; c < 17; c++) begin
            check($sformatf("baud_c%0d", c), 32'(bus.tx_enb), ((c % 4) == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Single byte to requester 0.
        bus.req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        bus.req      = 4'b0001;
        push(0, 8'hA5);
        @(negedge clk);
        check("latency_wr_enb", 32'(bus.wr_enb), 32'd1);
        bus.req = 4'b0000;
        n = 0;
        while (bus.ctrl_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("busy_order", 32'(tb_busy), 32'd0);
        check("line_frame", 32'(frame), 32'({1'b1, 8'hA5, 1'b0}));

        // Round robin with all requesters pending.
        do_reset();
        bus.req_data = {8'h3D, 8'h2C, 8'h1B, 8'h0A};
        push(0, 8'h0A); push(1, 8'h1B); push(2, 8'h2C);
        push(3, 8'h3D); push(0, 8'h0A); push(1, 8'h1B);
        n = frames;
        bus.req = 4'hF;
        wait_frames(n + 6, "rr_timeout");
        bus.req = 4'h0;
        wait_idle("rr_idle_timeout");

        // Reset while waiting for the transmitter to finish.
        do_reset();
        bus.req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        push(2, 8'h5A);
        n = frames;
        bus.req = 4'b0100;
        wait_frames(n + 1, "mid_grant_timeout");
        bus.req = 4'b0000;
        n = 0;
        while (tb_busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid_rst_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);
        check("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
        bus.req_data = {8'h00, 8'h00, 8'h77, 8'h66};
        bus.req      = 4'b0011;
        wr_seen      = 1'b0;
        repeat (50) @(negedge clk);
        check("no_wr_while_busy", 32'(wr_seen), 32'd0);
        push(0, 8'h66);
        push(1, 8'h77);
        n = frames;
        force_busy = 1'b0;
        wait_frames(n + 2, "post_rst_timeout");
        bus.req = 4'b0000;
        wait_idle("post_rst_idle_timeout");

`ifdef UART_TX_SCHED_LOCK_EN
        // Burst lock on requester 2, then released back to round robin.
        do_reset();
        bus.req_data = {8'h00, 8'h22, 8'h11, 8'h00};
        push(1, 8'h11); push(2, 8'h22); push(2, 8'h22);
        push(2, 8'h22); push(1, 8'h11);
        n = frames;
        bus.req = 4'b0110;
        wait_frames(n + 2, "lock_first_timeout");
        lock = 4'b0100;
        wait_frames(n + 4, "lock_burst_timeout");
        lock = 4'b0000;
        wait_frames(n + 5, "lock_release_timeout");
        bus.req = 4'b0000;
        wait_idle("lock_idle_timeout");
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
